// File: rtl/distance_countdown_ctrl_if.sv
// Control/readout bundle between the game FSM, the VGA timing generator and
// the distance countdown controller. Define DISTANCE_CTRL_BOOST_EN to add the
// i_boost request line.
interface distance_countdown_ctrl_if;
  logic        i_v_sync;
  logic        i_start;
  logic        i_pause;
  logic        i_load;
  logic [11:0] i_load_value;
`ifdef DISTANCE_CTRL_BOOST_EN
  logic        i_boost;
`endif
  logic [3:0]  o_hundreds;
  logic [3:0]  o_tens;
  logic [3:0]  o_units;
  logic        o_running;
  logic        o_done;
  logic [1:0]  o_state;

  modport master (
`ifdef DISTANCE_CTRL_BOOST_EN
    output i_boost,
`endif
    output i_v_sync, i_start, i_pause, i_load, i_load_value,
    input  o_hundreds, o_tens, o_units, o_running, o_done, o_state
  );

  modport slave (
`ifdef DISTANCE_CTRL_BOOST_EN
    input  i_boost,
`endif
    input  i_v_sync, i_start, i_pause, i_load, i_load_value,
    output o_hundreds, o_tens, o_units, o_running, o_done, o_state
  );
endinterface

// File: rtl/distance_countdown_ctrl.sv
// Distance readout sequencer: owns the 3-digit BCD distance, prescales VGA
// frames into countdown steps and decrements the value until 000.
// Optional macro DISTANCE_CTRL_BOOST_EN: adds i_boost, which halves the
// number of frames per step while in RUN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | value held, waiting for i_start
// RUN     | counting frames, decrementing once per step
// PAUSED  | frozen by i_pause, prescaler count kept
// DONE    | value reached 000, waiting for i_start to restart
module distance_countdown_ctrl #(
  parameter int          FRAMES_PER_STEP = 80,
  parameter logic [11:0] START_VALUE     = 12'h200
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  distance_countdown_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [7:0] FULL_TC = 8'(FRAMES_PER_STEP - 1);
`ifdef DISTANCE_CTRL_BOOST_EN
  localparam logic [7:0] HALF_TC = 8'((FRAMES_PER_STEP / 2) - 1);
`endif

  state_t      state_q, state_d;
  logic [11:0] digits_q, digits_d;
  logic [7:0]  presc_q, presc_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        hist_q, hist_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        frame_tick;
  logic        term_hit;
  logic [11:0] dec_value;

  function automatic logic [3:0] nib_clamp(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else if (t != 4'd0) begin
      t = t - 4'd1;
      u = 4'd9;
    end else begin
      h = h - 4'd1;
      t = 4'd9;
      u = 4'd9;
    end
    return {h, t, u};
  endfunction

  // Next-state, datapath and output computation; defaults hold everything.
  always_comb begin
    sync1_d    = bus.i_v_sync;
    sync2_d    = sync1_q;
    hist_d     = sync2_q;
    frame_tick = sync2_q & ~hist_q;
`ifdef DISTANCE_CTRL_BOOST_EN
    // >= rather than == so that raising boost past the halved count
    // steps on the very next tick.
    term_hit   = bus.i_boost ? (presc_q >= HALF_TC) : (presc_q >= FULL_TC);
`else
    term_hit   = (presc_q >= FULL_TC);
`endif
    dec_value  = bcd_dec(digits_q);

    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (bus.i_load) begin
      digits_d = {nib_clamp(bus.i_load_value[11:8]),
                  nib_clamp(bus.i_load_value[7:4]),
                  nib_clamp(bus.i_load_value[3:0])};
      presc_d  = 8'd0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            if (digits_q == 12'h000) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
              presc_d = 8'd0;
            end
          end
        end
        ST_RUN: begin
          if (bus.i_pause) begin
            // Entering pause discards any coincident tick or step.
            state_d = ST_PAUSED;
          end else if (frame_tick) begin
            if (term_hit) begin
              presc_d  = 8'd0;
              digits_d = dec_value;
              if (dec_value == 12'h000) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              presc_d = presc_q + 8'd1;
            end
          end
        end
        ST_PAUSED: begin
          if (!bus.i_pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (bus.i_start) begin
            digits_d = START_VALUE;
            presc_d  = 8'd0;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  // State, datapath and synchronizer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      digits_q  <= START_VALUE;
      presc_q   <= 8'd0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_hundreds = digits_q[11:8];
  assign bus.o_tens     = digits_q[7:4];
  assign bus.o_units    = digits_q[3:0];
  assign bus.o_running  = running_q;
  assign bus.o_done     = done_q;
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_distance_countdown_ctrl.sv
// Bench for distance_countdown_ctrl with FRAMES_PER_STEP=4. A decimal-valued
// model predicts every output on every cycle; literal checks pin the model.
module tb_distance_countdown_ctrl;
  localparam int FPS   = 4;
  localparam int START = 200;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  bit   started  = 0;
  bit   coin_hit = 0;

  distance_countdown_ctrl_if dif();

  distance_countdown_ctrl #(
    .FRAMES_PER_STEP(FPS),
    .START_VALUE(12'h200)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: value kept as a plain decimal number, state as 0..3
  int m_val = START;
  int m_st  = 0;
  int m_cnt = 0;
  bit m_done = 0;
  bit s1 = 0, s2 = 0, s3 = 0;

  function automatic int clampn(input int n);
    return (n > 9) ? 9 : n;
  endfunction

  always @(posedge clk) begin
    bit tick;
    int term;
    started = 1;
    tick = s2 & ~s3;
`ifdef DISTANCE_CTRL_BOOST_EN
    term = dif.i_boost ? FPS / 2 : FPS;
`else
    term = FPS;
`endif
    m_done = 0;
    if (!rst_n) begin
      m_val = START; m_st = 0; m_cnt = 0;
      s1 = 0; s2 = 0; s3 = 0;
    end else begin
      if (dif.i_load && tick && m_st == 1 && !dif.i_pause && m_cnt + 1 >= term)
        coin_hit = 1;
      if (dif.i_load) begin
        m_val = clampn(int'(dif.i_load_value[11:8])) * 100 +
                clampn(int'(dif.i_load_value[7:4])) * 10 +
                clampn(int'(dif.i_load_value[3:0]));
        m_cnt = 0; m_st = 0;
      end else if (m_st == 0) begin
        if (dif.i_start) begin
          if (m_val == 0) begin m_st = 3; m_done = 1; end
          else begin m_st = 1; m_cnt = 0; end
        end
      end else if (m_st == 1) begin
        if (dif.i_pause) m_st = 2;
        else if (tick) begin
          if (m_cnt + 1 >= term) begin
            m_cnt = 0;
            m_val = m_val - 1;
            if (m_val == 0) begin m_st = 3; m_done = 1; end
          end else m_cnt = m_cnt + 1;
        end
      end else if (m_st == 2) begin
        if (!dif.i_pause) m_st = 1;
      end else begin
        if (dif.i_start) begin m_val = START; m_st = 1; m_cnt = 0; end
      end
      s3 = s2; s2 = s1; s1 = dif.i_v_sync;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic [18:0] exp_v, act_v;
    if (started) begin
      exp_v = {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10),
               2'(m_st), (m_st == 1), m_done};
      act_v = {dif.o_hundreds, dif.o_tens, dif.o_units,
               dif.o_state, dif.o_running, dif.o_done};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t got=%h expected=%h", $time, act_v, exp_v);
      end
      if (dif.o_done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vpulse(input int n);
    for (int i = 0; i < n; i++) begin
      dif.i_v_sync = 1'b1; cyc(3);
      dif.i_v_sync = 1'b0; cyc(3);
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    dif.i_load = 1'b1; dif.i_load_value = v; cyc(1);
    dif.i_load = 1'b0; cyc(1);
  endtask

  task automatic do_start;
    dif.i_start = 1'b1; cyc(1);
    dif.i_start = 1'b0; cyc(1);
  endtask

  function automatic logic [31:0] digits;
    return {20'd0, dif.o_hundreds, dif.o_tens, dif.o_units};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    dif.i_v_sync = 1'b0; dif.i_start = 1'b0; dif.i_pause = 1'b0;
    dif.i_load = 1'b0; dif.i_load_value = 12'h000;
`ifdef DISTANCE_CTRL_BOOST_EN
    dif.i_boost = 1'b0;
`endif
    cyc(2);
    check("reset_digits", digits(), 32'h200);
    check("reset_state", {30'd0, dif.o_state}, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // idle: frames without start change nothing
    vpulse(8);
    check("idle_digits", digits(), 32'h200);
    check("idle_state", {30'd0, dif.o_state}, 32'd0);
    check("idle_running", {31'd0, dif.o_running}, 32'd0);

    // borrow through tens and hundreds
    do_load(12'h100);
    do_start();
    check("run_running", {31'd0, dif.o_running}, 32'd1);
    vpulse(4);
    check("borrow_099", digits(), 32'h099);
    vpulse(4);
    check("borrow_098", digits(), 32'h098);

    // finish at 000 with a single done pulse
    do_load(12'h002);
    done_cnt = 0;
    do_start();
    vpulse(4);
    check("finish_001", digits(), 32'h001);
    vpulse(4);
    check("finish_000", digits(), 32'h000);
    check("finish_state", {30'd0, dif.o_state}, 32'd3);
    check("finish_done_cnt", done_cnt, 32'd1);
    vpulse(4);
    check("done_hold", digits(), 32'h000);
    check("done_no_repulse", done_cnt, 32'd1);

    // restart from DONE, then pause keeps the prescaler count
    do_start();
    check("restart_digits", digits(), 32'h200);
    vpulse(2);
    dif.i_pause = 1'b1; cyc(2);
    check("paused_state", {30'd0, dif.o_state}, 32'd2);
    vpulse(10);
    dif.i_pause = 1'b0; cyc(2);
    vpulse(1);
    check("pause_no_step", digits(), 32'h200);
    vpulse(1);
    check("pause_step_199", digits(), 32'h199);
    check("pause_state_run", {30'd0, dif.o_state}, 32'd1);

    // load coincident with a step tick: load wins, nibbles clamp
    vpulse(3);
    coin_hit = 0;
    dif.i_v_sync = 1'b1; cyc(2);
    dif.i_load = 1'b1; dif.i_load_value = 12'hFA3; cyc(1);
    dif.i_load = 1'b0; cyc(2);
    dif.i_v_sync = 1'b0; cyc(3);
    check("load_coincident", {31'd0, coin_hit}, 32'd1);
    check("load_clamp", digits(), 32'h993);
    check("load_state_idle", {30'd0, dif.o_state}, 32'd0);

    // start with 000 goes straight to DONE
    do_load(12'h000);
    done_cnt = 0;
    do_start();
    check("zero_start_state", {30'd0, dif.o_state}, 32'd3);
    check("zero_start_done", done_cnt, 32'd1);

    // boost (when built in), then reset mid-run
    do_load(12'h050);
    do_start();
`ifdef DISTANCE_CTRL_BOOST_EN
    dif.i_boost = 1'b1;
    vpulse(2);
`else
    vpulse(4);
`endif
    check("step_049", digits(), 32'h049);
    vpulse(1);
    rst_n = 1'b0; cyc(1);
    rst_n = 1'b1;
    check("midrun_reset_digits", digits(), 32'h200);
    check("midrun_reset_state", {30'd0, dif.o_state}, 32'd0);
    check("midrun_reset_running", {31'd0, dif.o_running}, 32'd0);
`ifdef DISTANCE_CTRL_BOOST_EN
    dif.i_boost = 1'b0;
`endif
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
